// File: rtl/csr_file.sv
// Machine-mode CSR file: 64-bit cycle/instret counters, mscratch and mhartid.
// Reads are combinational and return the pre-update value. Writes, sets and
// clears commit on the next rising clk edge. The datapath assumes XLEN >= 32,
// and each counter half is 32 bits wide.
module csr_file #(
  parameter int XLEN        = 32,
  parameter int CSR_CMD_LEN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_en,
  input  logic [CSR_CMD_LEN-1:0] csr_cmd,
  input  logic [11:0]            csr_addr,
  input  logic [XLEN-1:0]        wdata,
  input  logic                   retire,
  output logic [XLEN-1:0]        rdata,
  output logic                   illegal
);

  // Command encoding shared with the decoder.
  localparam logic [CSR_CMD_LEN-1:0] CSR_READ  = CSR_CMD_LEN'(0);
  localparam logic [CSR_CMD_LEN-1:0] CSR_WRITE = CSR_CMD_LEN'(1);
  localparam logic [CSR_CMD_LEN-1:0] CSR_SET   = CSR_CMD_LEN'(2);
  localparam logic [CSR_CMD_LEN-1:0] CSR_CLEAR = CSR_CMD_LEN'(3);

  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_TIME      = 12'hC01;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  logic [63:0]     mcycle_reg, mcycle_next;
  logic [63:0]     minstret_reg, minstret_next;
  logic [XLEN-1:0] mscratch_reg, mscratch_next;

  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            implemented;
  logic            write_en;

  // Decode the address and select the current (pre-update) CSR value.
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_addr)
      ADDR_MCYCLE, ADDR_CYCLE, ADDR_TIME:        old_val = XLEN'(mcycle_reg[31:0]);
      ADDR_MCYCLEH, ADDR_CYCLEH, ADDR_TIMEH:     old_val = XLEN'(mcycle_reg[63:32]);
      ADDR_MINSTRET, ADDR_INSTRET:               old_val = XLEN'(minstret_reg[31:0]);
      ADDR_MINSTRETH, ADDR_INSTRETH:             old_val = XLEN'(minstret_reg[63:32]);
      ADDR_MSCRATCH:                             old_val = mscratch_reg;
      ADDR_MHARTID:                              old_val = '0;
      default:                                   implemented = 1'b0;
    endcase
  end

  // Apply the read-modify-write operation and classify the access.
  always_comb begin
    new_val = old_val;
    case (csr_cmd)
      CSR_WRITE: new_val = wdata;
      CSR_SET:   new_val = old_val | wdata;
      CSR_CLEAR: new_val = old_val & ~wdata;
      default:   new_val = old_val;
    endcase
    // The top two address bits equal to 11 mark a read-only CSR.
    illegal  = csr_en & (~implemented |
               ((csr_addr[11:10] == 2'b11) & (csr_cmd != CSR_READ)));
    write_en = csr_en & (csr_cmd != CSR_READ) & ~illegal;
    rdata    = csr_en ? old_val : '0;
  end

  // Compute next counter and scratch values. A write to one half wins over
  // that cycle's increment and leaves the other half untouched.
  always_comb begin
    mcycle_next   = mcycle_reg + 64'd1;
    minstret_next = minstret_reg + 64'(retire);
    mscratch_next = mscratch_reg;
    if (write_en) begin
      case (csr_addr)
        ADDR_MCYCLE:    mcycle_next   = {mcycle_reg[63:32], new_val[31:0]};
        ADDR_MCYCLEH:   mcycle_next   = {new_val[31:0], mcycle_reg[31:0]};
        ADDR_MINSTRET:  minstret_next = {minstret_reg[63:32], new_val[31:0]};
        ADDR_MINSTRETH: minstret_next = {new_val[31:0], minstret_reg[31:0]};
        ADDR_MSCRATCH:  mscratch_next = new_val;
        default:        mscratch_next = mscratch_reg;
      endcase
    end
  end

  // State registers. Reset overrides any concurrent access or retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_reg   <= '0;
      minstret_reg <= '0;
      mscratch_reg <= '0;
    end else begin
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;
      mscratch_reg <= mscratch_next;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file. Each step drives one cycle of stimulus,
// queues the expected rdata/illegal and checks them mid-cycle.
module tb_csr_file;

  localparam logic [1:0] RD = 2'd0;
  localparam logic [1:0] WR = 2'd1;
  localparam logic [1:0] ST = 2'd2;
  localparam logic [1:0] CL = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_cmd = RD;
  logic [11:0] csr_addr = '0;
  logic [31:0] wdata = '0;
  logic        retire = 1'b0;
  logic [31:0] rdata;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  csr_file #(.XLEN(32), .CSR_CMD_LEN(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .csr_en   (csr_en),
    .csr_cmd  (csr_cmd),
    .csr_addr (csr_addr),
    .wdata    (wdata),
    .retire   (retire),
    .rdata    (rdata),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // One cycle: drive at the falling edge, check 1 time unit later,
  // then let the rising edge commit and return at the next falling edge.
  task automatic step(input string tag, input logic en, input logic [1:0] cmd,
                      input logic [11:0] addr, input logic [31:0] wd,
                      input logic ret, input logic [31:0] exp_rd,
                      input logic exp_ill);
    exp_t e;
    csr_en   = en;
    csr_cmd  = cmd;
    csr_addr = addr;
    wdata    = wd;
    retire   = ret;
    e.tag    = tag;
    e.rdata  = exp_rd;
    e.ill    = exp_ill;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    n_checks++;
    assert (rdata === e.rdata) else begin
      n_fail++;
      $error("FAIL %s rdata: got %h, expected %h", e.tag, rdata, e.rdata);
    end
    n_checks++;
    assert (illegal === e.ill) else begin
      n_fail++;
      $error("FAIL %s illegal: got %b, expected %b", e.tag, illegal, e.ill);
    end
    $display("step %-12s en=%b cmd=%0d addr=%h wdata=%h retire=%b -> rdata=%h illegal=%b",
             e.tag, en, cmd, addr, wd, ret, rdata, illegal);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset held: outputs quiet with csr_en=0
    step("rst_quiet", 1'b0, RD, 12'hC00, 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;

    // Counting starts right after reset
    step("cyc_first",  1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'd0, 1'b0);
    step("cyc_second", 1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'd1, 1'b0);
    for (int i = 0; i < 8; i++)
      step("idle", 1'b0, RD, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    step("cycle_10",  1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'd10, 1'b0);
    step("cycleh_0",  1'b1, RD, 12'hC80, 32'h0, 1'b0, 32'd0, 1'b0);
    step("time_12",   1'b1, RD, 12'hC01, 32'h0, 1'b0, 32'd12, 1'b0);

    // mscratch read-modify-write
    step("msc_write", 1'b1, WR, 12'h340, 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
    step("msc_set",   1'b1, ST, 12'h340, 32'h0000_00FF, 1'b0, 32'hA5A5_0000, 1'b0);
    step("msc_clear", 1'b1, CL, 12'h340, 32'hA000_000F, 1'b0, 32'hA5A5_00FF, 1'b0);
    step("msc_final", 1'b1, RD, 12'h340, 32'h0, 1'b0, 32'h05A5_00F0, 1'b0);

    // Carry from low into high half of mcycle
    step("mc_wr_lo",     1'b1, WR, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'd17, 1'b0);
    step("idle",         1'b0, RD, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    step("carry_lo",     1'b1, RD, 12'hB00, 32'h0, 1'b0, 32'h0, 1'b0);
    step("carry_hi",     1'b1, RD, 12'hB80, 32'h0, 1'b0, 32'h1, 1'b0);
    step("carry_cycleh", 1'b1, RD, 12'hC80, 32'h0, 1'b0, 32'h1, 1'b0);

    // minstret write beats concurrent retire, then counts retires
    step("minst_0",    1'b1, RD, 12'hB02, 32'h0, 1'b0, 32'd0, 1'b0);
    step("minst_wr",   1'b1, WR, 12'hB02, 32'd5, 1'b1, 32'd0, 1'b0);
    step("minst_5",    1'b1, RD, 12'hB02, 32'h0, 1'b1, 32'd5, 1'b0);
    step("retire",     1'b0, RD, 12'h000, 32'h0, 1'b1, 32'h0, 1'b0);
    step("retire",     1'b0, RD, 12'h000, 32'h0, 1'b1, 32'h0, 1'b0);
    step("instret_8",  1'b1, RD, 12'hC02, 32'h0, 1'b0, 32'd8, 1'b0);
    step("instreth_0", 1'b1, RD, 12'hC82, 32'h0, 1'b0, 32'd0, 1'b0);

    // Writing the high half holds the low half without incrementing it
    step("cycle_0a", 1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'h0A, 1'b0);
    step("mch_wr",   1'b1, WR, 12'hB80, 32'h0, 1'b0, 32'h1, 1'b0);
    step("hold_lo",  1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'h0B, 1'b0);
    step("hold_hi",  1'b1, RD, 12'hC80, 32'h0, 1'b0, 32'h0, 1'b0);

    // Illegal accesses
    step("ro_write",   1'b1, WR, 12'hC00, 32'h0, 1'b0, 32'h0D, 1'b1);
    step("ro_unaff",   1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'h0E, 1'b0);
    step("unimpl",     1'b1, RD, 12'h7FF, 32'h0, 1'b0, 32'h0, 1'b1);
    step("hartid",     1'b1, RD, 12'hF14, 32'h0, 1'b0, 32'h0, 1'b0);
    step("hartid_set", 1'b1, ST, 12'hF14, 32'h1, 1'b0, 32'h0, 1'b1);

    // Both counters to all ones, then wrap together
    step("mi_wr_lo",  1'b1, WR, 12'hB02, 32'hFFFF_FFFF, 1'b0, 32'd8, 1'b0);
    step("mi_wr_hi",  1'b1, WR, 12'hB82, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    step("mc_wr_lo2", 1'b1, WR, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h14, 1'b0);
    step("mc_wr_hi2", 1'b1, WR, 12'hB80, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    step("wrap_pre",  1'b1, RD, 12'hB00, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step("wrap_mc_lo", 1'b1, RD, 12'hB00, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap_mc_hi", 1'b1, RD, 12'hB80, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap_mi_lo", 1'b1, RD, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap_mi_hi", 1'b1, RD, 12'hB82, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset mid-count with a concurrent write and retire
    step("pre_rst",  1'b1, RD, 12'hB02, 32'h0, 1'b1, 32'd0, 1'b0);
    step("pre_rst2", 1'b1, RD, 12'hB02, 32'h0, 1'b1, 32'd1, 1'b0);
    reset = 1'b1;
    step("rst_busy", 1'b1, WR, 12'h340, 32'h1234_5678, 1'b1, 32'h05A5_00F0, 1'b0);
    reset = 1'b0;
    step("rst_mc",  1'b1, RD, 12'hC00, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst_mch", 1'b1, RD, 12'hC80, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst_mi",  1'b1, RD, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst_ms",  1'b1, RD, 12'h340, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL take parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL take parameter CSR_CMD_LEN, default from constants.vh, width of the csr_cmd encoding (CSR_READ/CSR_WRITE/CSR_SET/CSR_CLEAR).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port csr_en  input  1  a SYSTEM CSR instruction is executing this cycle.
REQ-006 SHALL have port csr_cmd  input  CSR_CMD_LEN  command from the decoder.
REQ-007 SHALL have port csr_addr  input  12  CSR address, inst[31:20].
REQ-008 SHALL have port wdata  input  XLEN  operand, already muxed between rs1 and zero-extended zimm by csr_sel.
REQ-009 SHALL have port retire  input  1  one instruction retires this cycle.
REQ-010 SHALL have port rdata  output  XLEN  old CSR value, written back as rd.
REQ-011 SHALL have port illegal  output  1  illegal CSR access this cycle.

Function
REQ-012 SHALL implement these CSRs:
- mcycle 0xB00 / mcycleh 0xB80: read/write.
- minstret 0xB02 / minstreth 0xB82: read/write.
- cycle 0xC00, time 0xC01, instret 0xC02 and their high halves 0xC80/0xC81/0xC82: read-only.
- mscratch 0x340: read/write.
- mhartid 0xF14: read-only, constant 0.
REQ-013 SHALL back mcycle and minstret each with one 64-bit counter; cycle and time alias mcycle, and instret aliases minstret.
REQ-014 SHALL drive rdata combinationally with the pre-update value of the addressed CSR, and drive 0 for an unimplemented address.
REQ-015 SHALL compute the new value as:
- CSR_WRITE: wdata.
- CSR_SET: old | wdata.
- CSR_CLEAR: old & ~wdata.
- CSR_READ: no write.
REQ-016 SHALL commit the new value on the next rising clk only when csr_en=1, the command is not CSR_READ, and illegal=0.
REQ-017 SHALL assert illegal=csr_en & (address unimplemented | (csr_addr[11:10]==2'b11 & csr_cmd!=CSR_READ)); illegal SHALL be 0 whenever csr_en=0.
REQ-018 SHALL increment mcycle by 1 every cycle that reset=0, with the carry from bit 31 propagating into bit 32 within the same cycle.
REQ-019 SHALL increment minstret by 1 in each cycle that retire=1.
REQ-020 SHALL wrap both counters from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag raised.
REQ-021 SHALL give a CSR write to either half of a counter priority over that cycle's increment:
- The written half takes exactly the new value.
- The other half holds, with no carry applied.
REQ-022 SHALL, when one counter half is written, leave the other half unchanged.
REQ-023 SHALL make a write visible on rdata in the cycle after the command.
REQ-024 SHALL return the value of a counter read in the same cycle as its pre-increment value.

Reset
REQ-025 SHALL, while reset=1 at a rising clk, clear mcycle, minstret and mscratch to 0, regardless of any concurrent csr_en, csr_cmd or retire.
REQ-026 SHALL begin counting in the first cycle after reset deasserts, so mcycle reads 0 in that cycle and 1 in the next.
REQ-027 SHALL keep rdata and illegal purely combinational from current state and inputs, so that with csr_en=0 they read 0 during reset.

Verification
REQ-028 SHALL pass: reset, then 10 idle cycles, then read 0xC00 -> rdata=10; read 0xC80 -> rdata=0.
REQ-029 SHALL pass: CSR_WRITE 0x340 with 0xA5A5_0000, then CSR_SET 0x340 with 0x0000_00FF, then CSR_CLEAR 0x340 with 0xA000_000F:
- rdata returns 0, then 0xA5A5_0000, then 0xA5A5_00FF.
- Final mscratch=0x05A5_00F0.
REQ-030 SHALL pass: CSR_WRITE 0xB00 with 0xFFFF_FFFF, then 1 idle cycle -> mcycle=0x0000_0001_0000_0000, i.e. a carry into the high half.
REQ-031 SHALL pass: CSR_WRITE 0xB02 with 5 and retire=1 in the same cycle -> minstret reads 5 next cycle; then retire=1 for 3 cycles -> minstret reads 8.
REQ-032 SHALL pass: CSR_WRITE 0xC00 with csr_en=1 -> illegal=1 and mcycle is unaffected; CSR_READ 0x7FF -> illegal=1 and rdata=0; CSR_READ 0xF14 -> illegal=0 and rdata=0.
REQ-033 SHALL pass: mcycle and minstret both set to 0xFFFF_FFFF_FFFF_FFFF with retire=1 for one cycle -> both read 0 next cycle; asserting reset mid-count -> all counters read 0 after that edge.
